// File: rtl/mat_mul_pkg.sv
// Shared constants and types for the matrix-multiply memory manager and the
// result-memory writer.
//   DATA_W : operand width (products are 2*DATA_W)
//   K      : products per dot product
//   N_COLS : dot products per pass
//   ADDR_W : result address width
//   ACC_W  : accumulator width, large enough for K worst-case products
package mat_mul_pkg;

  localparam int DATA_W = 8;
  localparam int K      = 8;
  localparam int K_W    = 3;
  localparam int N_COLS = 16;
  localparam int ADDR_W = 4;
  localparam int ACC_W  = 19;
  localparam int PROD_W = 2 * DATA_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Sign-extend a product to accumulator width
  function automatic logic [ACC_W-1:0] sext_prod(input logic [PROD_W-1:0] p);
    return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
  endfunction

endpackage

// File: rtl/res_accumulator.sv
// Signed dot-product accumulator with its product counter.
//   clk, rst : clock, async active-low reset
//   clr_i    : zero accumulator and counter
//   en_i     : accept one product (data_i)
//   sum_o    : accumulator plus current product (value after this transfer)
//   last_o   : the next accepted product completes the dot product
module res_accumulator
  import mat_mul_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [PROD_W-1:0] data_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              last_o
);

  logic [ACC_W-1:0] acc_q;
  logic [K_W-1:0]   k_q;

  // Modulo-2^ACC_W add is the two's complement sum; width rules out overflow
  assign sum_o  = acc_q + sext_prod(data_i);
  assign last_o = (k_q == K_W'(K - 1));

  // Accumulator and product counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= {ACC_W{1'b0}};
      k_q   <= {K_W{1'b0}};
    end else if (clr_i) begin
      acc_q <= {ACC_W{1'b0}};
      k_q   <= {K_W{1'b0}};
    end else if (en_i) begin
      acc_q <= sum_o;
      k_q   <= last_o ? {K_W{1'b0}} : k_q + 1'b1;
    end else begin
      acc_q <= acc_q;
      k_q   <= k_q;
    end
  end

endmodule

// File: rtl/res_mem_writer.sv
// Result-memory writer: accumulates K products per column and writes each
// finished dot product to the result RAM at a self-generated address.
//   clk, rst          : clock, async active-low reset
//   start             : begin a pass (honoured only in IDLE or DONE)
//   in_valid/in_ready : product handshake, in_data is the signed product
//   Dir_R/wr_en/wr_data : result RAM write port
//   busy              : pass in progress, done : pass complete (held)
module res_mem_writer
  import mat_mul_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_data,
  output logic [ADDR_W-1:0] Dir_R,
  output logic              wr_en,
  output logic [ACC_W-1:0]  wr_data,
  output logic              busy,
  output logic              done
);

  state_e            state_q;
  logic [ADDR_W-1:0] col_q;
  logic              in_ready_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] dir_r_q;
  logic [ACC_W-1:0]  wr_data_q;
  logic              busy_q;
  logic              done_q;

  logic              xfer_s;
  logic              start_ok_s;
  logic              clr_s;
  logic [ACC_W-1:0]  sum_s;
  logic              last_s;

  // in_ready_q is only ever 1 in ACCUM, so this is the only transfer condition
  assign xfer_s     = in_valid & in_ready_q;
  assign start_ok_s = start & ((state_q == IDLE) | (state_q == DONE));
  // Clearing in WRITE readies the accumulator for the next column
  assign clr_s      = start_ok_s | (state_q == WRITE);

  res_accumulator u_acc (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (clr_s),
    .en_i   (xfer_s),
    .data_i (in_data),
    .sum_o  (sum_s),
    .last_o (last_s)
  );

  // Pass FSM with column counter and registered write-port outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      col_q      <= {ADDR_W{1'b0}};
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      dir_r_q    <= {ADDR_W{1'b0}};
      wr_data_q  <= {ACC_W{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q    <= ACCUM;
            col_q      <= {ADDR_W{1'b0}};
            dir_r_q    <= {ADDR_W{1'b0}};
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
          end else begin
            state_q <= state_q;
          end
        end
        ACCUM: begin
          if (xfer_s && last_s) begin
            state_q    <= WRITE;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b1;
            dir_r_q    <= col_q;
            wr_data_q  <= sum_s;
          end else begin
            state_q <= ACCUM;
          end
        end
        WRITE: begin
          wr_en_q <= 1'b0;
          if (col_q == ADDR_W'(N_COLS - 1)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q    <= ACCUM;
            col_q      <= col_q + 1'b1;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b0;
          wr_en_q    <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready = in_ready_q;
  assign wr_en    = wr_en_q;
  assign Dir_R    = dir_r_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
